// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of mem_port_arbiter.
// slave : the arbiter's view (takes requests, drives the memory bus).
// master: the surrounding datapath/memory view.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // fetch requester
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_instr;
   logic                  if_done;
   // data requester
   logic                  dm_read;
   logic                  dm_write;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  dm_done;
   logic                  stall;
   // unified memory port
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;
   logic                  timeout_err;

   modport slave (
      input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
             mem_rdata, mem_ack,
      output if_instr, if_done, dm_rdata, dm_done, stall,
             mem_req, mem_we, mem_addr, mem_wdata, timeout_err
   );

   modport master (
      output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata,
             mem_rdata, mem_ack,
      input  if_instr, if_done, dm_rdata, dm_done, stall,
             mem_req, mem_we, mem_addr, mem_wdata, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between
// instruction fetch and data load/store. Data has fixed priority over
// fetch; each access is a req/ack handshake followed by one response
// cycle carrying the matching done pulse. stall holds PC and pipeline
// registers while a request is outstanding.
// Optional feature macro: MEM_TIMEOUT_EN -- per-access wait counter that
// abandons an access after TIMEOUT_CYCLES un-acked cycles and sets the
// sticky timeout_err flag. Without it the FSM waits forever for mem_ack.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

   state_t                state;
   logic                  issue;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] instr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  if_pulse;
   logic                  dm_pulse;
   logic                  data_pending;

   // A zero limit would time out before the memory could ever answer.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_flag;
`endif

   // A simultaneous read+write is treated as a write.
   assign data_pending = bus.dm_read | bus.dm_write;

   // Sequencer: sample requests in IDLE, hold the memory bus until ack
   // (or timeout), then spend one RESP cycle pulsing the matching done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         issue    <= 1'b0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         instr    <= '0;
         rdata    <= '0;
         if_pulse <= 1'b0;
         dm_pulse <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         if_pulse <= 1'b0;
         dm_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (data_pending) begin
                  addr  <= bus.dm_addr;
                  wdata <= bus.dm_wdata;
                  we    <= bus.dm_write;
                  issue <= 1'b1;
                  state <= DATA;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else if (bus.if_req) begin
                  addr  <= bus.if_addr;
                  we    <= 1'b0;
                  issue <= 1'b1;
                  state <= FETCH;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            FETCH, DATA: begin
               if (bus.mem_ack) begin
                  issue <= 1'b0;
                  we    <= 1'b0;
                  state <= RESP;
                  if (state == FETCH) begin
                     instr    <= bus.mem_rdata;
                     if_pulse <= 1'b1;
                  end else begin
                     // stores leave the last load value untouched
                     if (!we) rdata <= bus.mem_rdata;
                     dm_pulse <= 1'b1;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  // abandon the access; a zero instruction is a NOP
                  issue        <= 1'b0;
                  we           <= 1'b0;
                  state        <= RESP;
                  timeout_flag <= 1'b1;
                  if (state == FETCH) begin
                     instr    <= '0;
                     if_pulse <= 1'b1;
                  end else begin
                     if (!we) rdata <= '0;
                     dm_pulse <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               // held requests are ignored here so they are never reissued
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = issue;
   assign bus.mem_we    = we;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = wdata;
   assign bus.if_instr  = instr;
   assign bus.if_done   = if_pulse;
   assign bus.dm_rdata  = rdata;
   assign bus.dm_done   = dm_pulse;
   assign bus.stall     = (bus.if_req & ~if_pulse) | (data_pending & ~dm_pulse);

`ifdef MEM_TIMEOUT_EN
   assign bus.timeout_err = timeout_flag;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked
// every cycle, a variable-latency memory responder, and directed vectors
// with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic clk;
   logic reset;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   bit cmp_en = 0;

   // memory responder state
   int          ack_delay = 1;      // ack in this mem_req cycle; 0 = never
   logic        resp_ack;
   logic [31:0] resp_rdata;
   logic        stray_ack;
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] log_addr [$];
   logic        log_we [$];
   logic [31:0] log_wdata [$];
   int          log_len [$];
   bit          addr_stable;

   assign bus.mem_ack   = resp_ack | stray_ack;
   assign bus.mem_rdata = resp_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_busy;     // an access owns the memory
   bit          m_fetch;
   bit          m_we;
   logic [31:0] m_addr, m_wdata, m_instr, m_rdata;
   int          m_waited;
   logic [1:0]  m_done;     // 0 none, 1 fetch done, 2 data done
   bit          m_terr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 0; m_fetch <= 0; m_we <= 0; m_addr <= 0; m_wdata <= 0;
         m_instr <= 0; m_rdata <= 0; m_waited <= 0; m_done <= 0; m_terr <= 0;
      end else if (m_busy) begin
         if (bus.mem_ack) begin
            m_busy <= 0;
            m_done <= m_fetch ? 2'd1 : 2'd2;
            if (m_fetch) m_instr <= bus.mem_rdata;
            else if (!m_we) m_rdata <= bus.mem_rdata;
         end else begin
            m_waited <= m_waited + 1;
`ifdef MEM_TIMEOUT_EN
            if (m_waited + 1 == TO) begin
               m_busy <= 0;
               m_terr <= 1;
               m_done <= m_fetch ? 2'd1 : 2'd2;
               if (m_fetch) m_instr <= 0;
               else if (!m_we) m_rdata <= 0;
            end
`endif
         end
      end else if (m_done != 0) begin
         m_done <= 0;   // response cycle: requests are not looked at
      end else if (bus.dm_read | bus.dm_write) begin
         m_busy <= 1; m_fetch <= 0; m_we <= bus.dm_write;
         m_addr <= bus.dm_addr; m_wdata <= bus.dm_wdata; m_waited <= 0;
      end else if (bus.if_req) begin
         m_busy <= 1; m_fetch <= 1; m_we <= 0;
         m_addr <= bus.if_addr; m_waited <= 0;
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cmp_en && !reset) begin
            check_bit("mem_req", bus.mem_req, m_busy);
            if (m_busy) check_bit("mem_we", bus.mem_we, m_we);
            if (m_busy && m_we) check32("mem_wdata", bus.mem_wdata, m_wdata);
            check32("mem_addr", bus.mem_addr, m_addr);
            check_bit("if_done", bus.if_done, m_done == 2'd1);
            check_bit("dm_done", bus.dm_done, m_done == 2'd2);
            check32("if_instr", bus.if_instr, m_instr);
            check32("dm_rdata", bus.dm_rdata, m_rdata);
            check_bit("timeout_err", bus.timeout_err, m_terr);
            check_bit("stall", bus.stall,
                      (bus.if_req & (m_done != 2'd1)) |
                      ((bus.dm_read | bus.dm_write) & (m_done != 2'd2)));
         end
      end
   end

   // variable-latency memory with an access log
   initial begin
      int cnt;
      logic [31:0] first;
      cnt = 0; first = 0;
      resp_ack = 0; resp_rdata = 0;
      forever begin
         @(negedge clk);
         resp_ack = 0;
         if (bus.mem_req) begin
            cnt++;
            if (cnt == 1) begin
               first = bus.mem_addr;
               log_addr.push_back(bus.mem_addr);
               log_we.push_back(bus.mem_we);
               log_wdata.push_back(bus.mem_wdata);
            end else if (bus.mem_addr !== first) begin
               addr_stable = 0;
            end
            if (ack_delay != 0 && cnt == ack_delay) begin
               resp_ack   = 1;
               resp_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
               if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
            end
         end else if (cnt != 0) begin
            log_len.push_back(cnt);
            cnt = 0;
         end
      end
   end

   task automatic clear_logs();
      log_addr.delete(); log_we.delete(); log_wdata.delete(); log_len.delete();
      addr_stable = 1;
   endtask

   // counts rising edges until the selected done pulse is seen
   task automatic wait_done(input bit data, input int budget, output int n);
      logic seen;
      n = 0; seen = 0;
      while (!seen && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         seen = data ? bus.dm_done : bus.if_done;
      end
      if (!seen) check_bit("done_wait_expired", 1'b0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1;
      stray_ack = 0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.dm_read = 0; bus.dm_write = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
      clear_logs();
      mem_arr[32'h00400000] = 32'h2008000A;
      mem_arr[32'h00400004] = 32'h8C090000;
      mem_arr[32'h00400008] = 32'h24090001;
      mem_arr[32'h10010000] = 32'h12345678;
      mem_arr[32'h10010008] = 32'h55555555;

      repeat (2) @(negedge clk);
      check_bit("rst_mem_req", bus.mem_req, 1'b0);
      check_bit("rst_mem_we", bus.mem_we, 1'b0);
      check32("rst_mem_addr", bus.mem_addr, 32'h0);
      check32("rst_if_instr", bus.if_instr, 32'h0);
      check32("rst_dm_rdata", bus.dm_rdata, 32'h0);
      check_bit("rst_if_done", bus.if_done, 1'b0);
      check_bit("rst_dm_done", bus.dm_done, 1'b0);
      check_bit("rst_timeout_err", bus.timeout_err, 1'b0);
      check_bit("rst_stall", bus.stall, 1'b0);
      reset = 0;
      cmp_en = 1;

      // fetch only, ack in the first mem_req cycle
      @(negedge clk);
      clear_logs(); ack_delay = 1;
      bus.if_addr = 32'h00400000; bus.if_req = 1;
      wait_done(0, 20, n);
      check_int("fetch_latency", n, 2);
      check_bit("fetch_stall_at_done", bus.stall, 1'b0);
      check32("fetch_instr", bus.if_instr, 32'h2008000A);
      @(negedge clk);
      bus.if_req = 0;
      @(posedge clk); #1;
      check32("fetch_addr", log_addr[0], 32'h00400000);
      check_bit("fetch_we", log_we[0], 1'b0);

      // store and fetch requested together: store wins
      @(negedge clk);
      clear_logs(); ack_delay = 1;
      bus.dm_write = 1; bus.dm_addr = 32'h10010004; bus.dm_wdata = 32'hDEADBEEF;
      bus.if_req = 1; bus.if_addr = 32'h00400004;
      wait_done(1, 20, n);
      check_int("store_latency", n, 2);
      @(negedge clk);
      bus.dm_write = 0;
      wait_done(0, 20, n);
      check_int("fetch_after_store_latency", n, 3);
      check32("fetch_after_store_instr", bus.if_instr, 32'h8C090000);
      @(negedge clk);
      bus.if_req = 0;
      @(posedge clk); #1;
      check_bit("store_first_we", log_we[0], 1'b1);
      check32("store_first_addr", log_addr[0], 32'h10010004);
      check32("store_first_wdata", log_wdata[0], 32'hDEADBEEF);
      check_bit("fetch_second_we", log_we[1], 1'b0);
      check32("fetch_second_addr", log_addr[1], 32'h00400004);
      check32("store_mem_written", mem_arr[32'h10010004], 32'hDEADBEEF);

      // load with wait states: ack in the 5th mem_req cycle
      @(negedge clk);
      clear_logs(); ack_delay = 5;
      bus.dm_read = 1; bus.dm_addr = 32'h10010000;
      wait_done(1, 30, n);
      check_int("load_wait_latency", n, 6);
      check32("load_wait_rdata", bus.dm_rdata, 32'h12345678);
      @(negedge clk);
      bus.dm_read = 0;
      @(posedge clk); #1;
      check_int("load_wait_req_cycles", log_len[0], 5);
      check_bit("load_wait_addr_stable", addr_stable, 1'b1);

      // read and write together behave as a write
      @(negedge clk);
      clear_logs(); ack_delay = 2;
      bus.dm_read = 1; bus.dm_write = 1;
      bus.dm_addr = 32'h10010008; bus.dm_wdata = 32'hCAFEF00D;
      wait_done(1, 20, n);
      check_int("rw_latency", n, 3);
      check32("rw_rdata_kept", bus.dm_rdata, 32'h12345678);
      @(negedge clk);
      bus.dm_read = 0; bus.dm_write = 0;
      @(posedge clk); #1;
      check_bit("rw_is_write", log_we[0], 1'b1);
      check32("rw_mem_written", mem_arr[32'h10010008], 32'hCAFEF00D);

      // stray ack while idle is ignored
      @(negedge clk);
      stray_ack = 1;
      @(negedge clk);
      stray_ack = 0;
      @(posedge clk); #1;
      check_bit("stray_ack_no_req", bus.mem_req, 1'b0);
      check_bit("stray_ack_no_dm_done", bus.dm_done, 1'b0);
      check_bit("stray_ack_no_if_done", bus.if_done, 1'b0);

      // asynchronous reset in the middle of a load
      @(negedge clk);
      clear_logs(); ack_delay = 0;
      bus.dm_read = 1; bus.dm_addr = 32'h10010000;
      repeat (3) @(negedge clk);
      check_bit("pre_reset_req", bus.mem_req, 1'b1);
      #2;
      reset = 1;
      bus.dm_read = 0;
      #1;
      check_bit("async_rst_mem_req", bus.mem_req, 1'b0);
      check32("async_rst_mem_addr", bus.mem_addr, 32'h0);
      check32("async_rst_dm_rdata", bus.dm_rdata, 32'h0);
      check32("async_rst_if_instr", bus.if_instr, 32'h0);
      check_bit("async_rst_dm_done", bus.dm_done, 1'b0);
      @(negedge clk);
      reset = 0;
      @(posedge clk); #1;
      check_bit("post_reset_no_done", bus.dm_done, 1'b0);

      // a normal fetch after the reset
      @(negedge clk);
      clear_logs(); ack_delay = 3;
      bus.if_addr = 32'h00400008; bus.if_req = 1;
      wait_done(0, 20, n);
      check_int("post_reset_fetch_latency", n, 4);
      check32("post_reset_fetch_instr", bus.if_instr, 32'h24090001);
      @(negedge clk);
      bus.if_req = 0;
      @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
      // fetch that is never acknowledged
      @(negedge clk);
      clear_logs(); ack_delay = 0;
      bus.if_addr = 32'h0040000C; bus.if_req = 1;
      wait_done(0, 20, n);
      check_int("timeout_latency", n, 5);
      check32("timeout_instr", bus.if_instr, 32'h0);
      check_bit("timeout_err_set", bus.timeout_err, 1'b1);
      @(negedge clk);
      bus.if_req = 0;
      repeat (3) @(posedge clk);
      #1;
      check_int("timeout_req_cycles", log_len[0], 4);
      check_bit("timeout_err_sticky", bus.timeout_err, 1'b1);
`else
      repeat (3) @(posedge clk);
      #1;
      check_bit("timeout_err_tied_low", bus.timeout_err, 1'b0);
`endif

      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
